demux_flow_ctrl: RTL and testbench

- Credit-based scheduler in front of the 6-bit lane demux.
- Arbitrates round-robin between two first-word-fall-through source FIFOs and pops at most one word per cycle.
- Sends each word to the demux only when its destination lane (data bit 5: 1 = lane 1, 0 = lane 0) holds a downstream credit.
- Thresholds are loaded in an INIT state; idle and error status are reported to the top-level test logic.

---
 rtl/demux_flow_ctrl_if.sv | 27 ++
 rtl/demux_flow_ctrl.sv | 145 ++++++++++++++
 tb/tb_demux_flow_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_flow_ctrl_if.sv
// Source-FIFO, demux and lane-return signals around the credit scheduler.
// Scheduler side is the slave modport; the FIFO/demux environment is the master.
`timescale 1ns/1ps
interface demux_flow_ctrl_if #(
  parameter int DATA_W = 6
);
  logic [DATA_W-1:0] src_data0;
  logic              src_empty0;
  logic [DATA_W-1:0] src_data1;
  logic              src_empty1;
  logic              lane_pop0;
  logic              lane_pop1;
  logic              pop0;
  logic              pop1;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;

  modport slave (
    input  src_data0, src_empty0, src_data1, src_empty1, lane_pop0, lane_pop1,
    output pop0, pop1, data_out, valid_out
  );

  modport master (
    output src_data0, src_empty0, src_data1, src_empty1, lane_pop0, lane_pop1,
    input  pop0, pop1, data_out, valid_out
  );
endinterface

// File: rtl/demux_flow_ctrl.sv
// Round-robin credit scheduler feeding the lane demux; DEMUX_FLOW_CTRL_STATS_EN adds sent counters.
// Pops are combinational, data_out/valid_out follow 1 cycle later; a lane with no credit stalls only its own words.
`timescale 1ns/1ps
module demux_flow_ctrl #(
  parameter int DATA_W   = 6,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [CREDIT_W-1:0] cfg_credit0,
  input  logic [CREDIT_W-1:0] cfg_credit1,
  demux_flow_ctrl_if.slave    bus,
  output logic [2:0]          state,
  output logic                idle,
  output logic                error
`ifdef DEMUX_FLOW_CTRL_STATS_EN
  ,
  output logic [7:0]          sent_cnt0,
  output logic [7:0]          sent_cnt1
`endif
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t              st, st_nxt;
  logic [CREDIT_W-1:0] credit0, credit1, limit0, limit1;
  logic                rr;
  logic                run, dst0, dst1;
  logic                elig0, elig1, grant0, grant1;
  logic                send0, send1, ovf0, ovf1;

  assign run  = (st == S_IDLE) || (st == S_ACTIVE);
  assign dst0 = bus.src_data0[DATA_W-1];
  assign dst1 = bus.src_data1[DATA_W-1];

  assign elig0 = run && !bus.src_empty0 && (dst0 ? (credit1 != '0) : (credit0 != '0));
  assign elig1 = run && !bus.src_empty1 && (dst1 ? (credit1 != '0) : (credit0 != '0));

  // rr=1 means source 0 was granted last, so source 1 wins a tie
  assign grant0 = elig0 && (!elig1 || !rr);
  assign grant1 = elig1 && (!elig0 || rr);

  assign send0 = (grant0 && !dst0) || (grant1 && !dst1);
  assign send1 = (grant0 && dst0) || (grant1 && dst1);

  assign ovf0 = run && bus.lane_pop0 && !send0 && (credit0 == limit0);
  assign ovf1 = run && bus.lane_pop1 && !send1 && (credit1 == limit1);

  function automatic logic [CREDIT_W-1:0] credit_upd(
    input logic [CREDIT_W-1:0] cr,
    input logic                ret,
    input logic                snd,
    input logic                ovf
  );
    if (ret && !snd && !ovf) return cr + CREDIT_W'(1);
    if (snd && !ret)         return cr - CREDIT_W'(1);
    return cr;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) st <= S_RESET;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      S_RESET:  st_nxt = S_INIT;
      S_INIT:   st_nxt = init ? S_INIT : S_IDLE;
      S_IDLE: begin
        if (ovf0 || ovf1)                          st_nxt = S_ERROR;
        else if (init)                             st_nxt = S_INIT;
        else if (!bus.src_empty0 || !bus.src_empty1) st_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (ovf0 || ovf1)                          st_nxt = S_ERROR;
        else if (bus.src_empty0 && bus.src_empty1) st_nxt = S_IDLE;
      end
      S_ERROR:  st_nxt = S_ERROR;
      default:  st_nxt = S_RESET;
    endcase
  end

  always_comb begin
    bus.pop0 = grant0;
    bus.pop1 = grant1;
    state    = st;
    error    = (st == S_ERROR);
    idle     = (st == S_IDLE) && (credit0 == limit0) && (credit1 == limit1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit0 <= '0;
      credit1 <= '0;
      limit0  <= '0;
      limit1  <= '0;
    end else if (st == S_INIT) begin
      credit0 <= cfg_credit0;
      credit1 <= cfg_credit1;
      limit0  <= cfg_credit0;
      limit1  <= cfg_credit1;
    end else if (run) begin
      credit0 <= credit_upd(credit0, bus.lane_pop0, send0, ovf0);
      credit1 <= credit_upd(credit1, bus.lane_pop1, send1, ovf1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr            <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      bus.valid_out <= grant0 || grant1;
      if (grant0) begin
        rr           <= 1'b1;
        bus.data_out <= bus.src_data0;
      end else if (grant1) begin
        rr           <= 1'b0;
        bus.data_out <= bus.src_data1;
      end
    end
  end

`ifdef DEMUX_FLOW_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sent_cnt0 <= '0;
      sent_cnt1 <= '0;
    end else begin
      if (send0 && sent_cnt0 != 8'hFF) sent_cnt0 <= sent_cnt0 + 8'd1;
      if (send1 && sent_cnt1 != 8'hFF) sent_cnt1 <= sent_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_flow_ctrl.sv
// Bench for demux_flow_ctrl: directed vector table, corner sequences, then random traffic vs a cycle model.
`timescale 1ns/1ps
module tb_demux_flow_ctrl;
  localparam int DW = 6;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [CW-1:0] cfg0, cfg1;
  logic [2:0]    state;
  logic          idle, error;
`ifdef DEMUX_FLOW_CTRL_STATS_EN
  logic [7:0]    sent_cnt0, sent_cnt1;
`endif

  demux_flow_ctrl_if #(.DATA_W(DW)) bus ();

  demux_flow_ctrl #(.DATA_W(DW), .CREDIT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .cfg_credit0 (cfg0),
    .cfg_credit1 (cfg1),
    .bus         (bus),
    .state       (state),
    .idle        (idle),
    .error       (error)
`ifdef DEMUX_FLOW_CTRL_STATS_EN
    ,
    .sent_cnt0   (sent_cnt0),
    .sent_cnt1   (sent_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, ini;
    logic [CW-1:0] c0, c1;
    logic [DW-1:0] d0;
    logic          e0;
    logic [DW-1:0] d1;
    logic          e1, lp0, lp1;
  } in_t;

  typedef struct {
    in_t           i;
    logic          p0, p1;
    logic [2:0]    st;
    logic          v;
    logic [DW-1:0] d;
    logic          idl, err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input bit rst, input bit ini, input int c0, input int c1,
                             input int d0, input bit e0, input int d1, input bit e1,
                             input bit lp0, input bit lp1);
    in_t r;
    r.rst = rst; r.ini = ini; r.c0 = CW'(c0); r.c1 = CW'(c1);
    r.d0 = DW'(d0); r.e0 = e0; r.d1 = DW'(d1); r.e1 = e1;
    r.lp0 = lp0; r.lp1 = lp1;
    return r;
  endfunction

  function automatic vec_t mkv(input in_t i, input bit p0, input bit p1, input int st,
                               input bit v, input int d, input bit idl, input bit err);
    vec_t r;
    r.i = i; r.p0 = p0; r.p1 = p1; r.st = 3'(st); r.v = v; r.d = DW'(d);
    r.idl = idl; r.err = err;
    return r;
  endfunction

  // Reference model: states as plain numbers, credits as integers, last winner remembered.
  int            m_st;
  int            cred[2];
  int            lim[2];
  int            last_win;
  logic          m_vld;
  logic [DW-1:0] m_dat;
  int            sent[2];
  logic          e_pop[2];

  task automatic model_comb(input in_t x);
    logic [DW-1:0] d[2];
    logic          emp[2];
    logic          ok[2];
    d[0] = x.d0; d[1] = x.d1; emp[0] = x.e0; emp[1] = x.e1;
    for (int s = 0; s < 2; s++)
      ok[s] = (m_st == 2 || m_st == 3) && !emp[s] && (cred[d[s][DW-1]] > 0);
    e_pop[0] = ok[0] && (!ok[1] || last_win == 1);
    e_pop[1] = ok[1] && (!ok[0] || last_win == 0);
  endtask

  task automatic model_update(input in_t x);
    logic [DW-1:0] d[2];
    int            snt[2];
    int            lp[2];
    int            cfg[2];
    bit            ovf;
    bit            run;
    if (x.rst) begin
      m_st = 0; cred = '{0, 0}; lim = '{0, 0}; last_win = 1;
      m_vld = 1'b0; m_dat = '0; sent = '{0, 0};
      return;
    end
    model_comb(x);
    d[0] = x.d0; d[1] = x.d1;
    lp[0] = int'(x.lp0); lp[1] = int'(x.lp1);
    cfg[0] = int'(x.c0); cfg[1] = int'(x.c1);
    snt = '{0, 0};
    for (int s = 0; s < 2; s++) begin
      if (e_pop[s]) begin
        snt[d[s][DW-1]] = 1;
        m_dat = d[s];
        last_win = s;
        if (sent[d[s][DW-1]] < 255) sent[d[s][DW-1]]++;
      end
    end
    m_vld = e_pop[0] || e_pop[1];
    run = (m_st == 2 || m_st == 3);
    ovf = 0;
    for (int i = 0; i < 2; i++) begin
      if (m_st == 1) begin
        cred[i] = cfg[i]; lim[i] = cfg[i];
      end else if (run) begin
        if (lp[i] == 1 && snt[i] == 0 && cred[i] == lim[i]) ovf = 1;
        else cred[i] = cred[i] + lp[i] - snt[i];
      end
    end
    case (m_st)
      0: m_st = 1;
      1: m_st = x.ini ? 1 : 2;
      2: m_st = ovf ? 4 : x.ini ? 1 : (!x.e0 || !x.e1) ? 3 : 2;
      3: m_st = ovf ? 4 : (x.e0 && x.e1) ? 2 : 3;
      default: m_st = 4;
    endcase
  endtask

  task automatic drive(input in_t x);
    @(negedge clk);
    reset = x.rst; init = x.ini; cfg0 = x.c0; cfg1 = x.c1;
    bus.src_data0 = x.d0; bus.src_empty0 = x.e0;
    bus.src_data1 = x.d1; bus.src_empty1 = x.e1;
    bus.lane_pop0 = x.lp0; bus.lane_pop1 = x.lp1;
    #1;
  endtask

  task automatic check_model();
    chk("m_pop0", bus.pop0, e_pop[0]);
    chk("m_pop1", bus.pop1, e_pop[1]);
    chk("m_state", state, m_st);
    chk("m_valid", bus.valid_out, m_vld);
    chk("m_data", bus.data_out, m_dat);
    chk("m_idle", idle, (m_st == 2 && cred[0] == lim[0] && cred[1] == lim[1]));
    chk("m_error", error, (m_st == 4));
`ifdef DEMUX_FLOW_CTRL_STATS_EN
    chk("m_sent0", sent_cnt0, sent[0]);
    chk("m_sent1", sent_cnt1, sent[1]);
`endif
  endtask

  task automatic pre(input in_t x);
    drive(x);
    model_comb(x);
    check_model();
  endtask

  task automatic post(input in_t x);
    @(posedge clk);
    model_update(x);
  endtask

  task automatic cyc(input in_t x);
    pre(x);
    post(x);
  endtask

  vec_t tbl[19];
  in_t  x;

  initial begin
    // Init load, round-robin drain of lane 0, then lane-1 blocking.
    tbl[0]  = mkv(mk(1,0,4,2,'h00,1,'h00,1,0,0), 0,0,0,0,'h00,0,0);
    tbl[1]  = mkv(mk(0,1,4,2,'h00,1,'h00,1,0,0), 0,0,0,0,'h00,0,0);
    tbl[2]  = mkv(mk(0,1,4,2,'h00,1,'h00,1,0,0), 0,0,1,0,'h00,0,0);
    tbl[3]  = mkv(mk(0,0,4,2,'h00,1,'h00,1,0,0), 0,0,1,0,'h00,0,0);
    tbl[4]  = mkv(mk(0,0,4,2,'h00,1,'h00,1,0,0), 0,0,2,0,'h00,1,0);
    tbl[5]  = mkv(mk(0,0,4,2,'h01,0,'h02,0,0,0), 1,0,2,0,'h00,1,0);
    tbl[6]  = mkv(mk(0,0,4,2,'h03,0,'h02,0,0,0), 0,1,3,1,'h01,0,0);
    tbl[7]  = mkv(mk(0,0,4,2,'h03,0,'h04,0,0,0), 1,0,3,1,'h02,0,0);
    tbl[8]  = mkv(mk(0,0,4,2,'h05,0,'h04,0,0,0), 0,1,3,1,'h03,0,0);
    tbl[9]  = mkv(mk(0,0,4,2,'h05,0,'h06,0,0,0), 0,0,3,1,'h04,0,0);
    tbl[10] = mkv(mk(0,0,4,2,'h05,0,'h06,0,0,0), 0,0,3,0,'h04,0,0);
    tbl[11] = mkv(mk(0,0,4,2,'h21,0,'h00,1,1,0), 1,0,3,0,'h04,0,0);
    tbl[12] = mkv(mk(0,0,4,2,'h22,0,'h00,1,1,0), 1,0,3,1,'h21,0,0);
    tbl[13] = mkv(mk(0,0,4,2,'h25,0,'h03,0,0,0), 0,1,3,1,'h22,0,0);
    tbl[14] = mkv(mk(0,0,4,2,'h25,0,'h00,1,0,0), 0,0,3,1,'h03,0,0);
    tbl[15] = mkv(mk(0,0,4,2,'h25,0,'h00,1,0,1), 0,0,3,0,'h03,0,0);
    tbl[16] = mkv(mk(0,0,4,2,'h25,0,'h00,1,0,0), 1,0,3,0,'h03,0,0);
    tbl[17] = mkv(mk(0,0,4,2,'h00,1,'h00,1,0,0), 0,0,3,1,'h25,0,0);
    tbl[18] = mkv(mk(0,0,4,2,'h00,1,'h00,1,0,0), 0,0,2,0,'h25,0,0);

    x = mk(1,0,4,2,'h00,1,'h00,1,0,0);
    drive(x);
    post(x);

    for (int k = 0; k < 19; k++) begin
      drive(tbl[k].i);
      chk($sformatf("row%0d_pop0", k), bus.pop0, tbl[k].p0);
      chk($sformatf("row%0d_pop1", k), bus.pop1, tbl[k].p1);
      chk($sformatf("row%0d_state", k), state, tbl[k].st);
      chk($sformatf("row%0d_valid", k), bus.valid_out, tbl[k].v);
      chk($sformatf("row%0d_data", k), bus.data_out, tbl[k].d);
      chk($sformatf("row%0d_idle", k), idle, tbl[k].idl);
      chk($sformatf("row%0d_error", k), error, tbl[k].err);
      post(tbl[k].i);
    end

    // Lane-0 credit is 1: a send and a lane_pop0 together must leave it at 1.
    x = mk(0,0,4,2,'h07,0,'h00,1,1,0); pre(x); chk("simul_pop0", bus.pop0, 1); post(x);
    x = mk(0,0,4,2,'h08,0,'h00,1,0,0); pre(x);
    chk("simul_credit_kept", bus.pop0, 1); chk("simul_no_error", error, 0);
    chk("simul_state", state, 3); chk("simul_data", bus.data_out, 'h07); post(x);
    x = mk(0,0,4,2,'h09,0,'h00,1,0,0); pre(x); chk("simul_drained", bus.pop0, 0); post(x);
    for (int k = 0; k < 4; k++) cyc(mk(0,0,4,2,'h00,1,'h00,1,1,(k < 2)));
    x = mk(0,0,4,2,'h00,1,'h00,1,0,0); pre(x);
    chk("restored_idle", idle, 1); chk("restored_state", state, 2); post(x);

    // Overflow on lane 1 at its limit, sticky until reset.
    x = mk(0,0,4,2,'h00,1,'h00,1,0,1); pre(x); post(x);
    for (int k = 0; k < 3; k++) begin
      x = mk(0,0,4,2,'h01,0,'h22,0,0,0); pre(x);
      chk("ovf_state", state, 4); chk("ovf_error", error, 1);
      chk("ovf_pop0", bus.pop0, 0); chk("ovf_pop1", bus.pop1, 0);
      chk("ovf_valid", bus.valid_out, 0); post(x);
    end
    x = mk(1,0,4,2,'h01,0,'h22,0,0,0); pre(x); post(x);
    x = mk(0,0,4,2,'h01,0,'h22,0,0,0); pre(x);
    chk("ovf_reset_state", state, 0); chk("ovf_reset_error", error, 0); post(x);
    cyc(mk(0,0,4,2,'h00,1,'h00,1,0,0));

    // Reset while a word is in flight.
    x = mk(0,0,4,2,'h01,0,'h02,0,0,0); pre(x); chk("mid_grant", bus.pop0 ^ bus.pop1, 1); post(x);
    x = mk(1,0,4,2,'h03,0,'h04,0,0,0); pre(x);
    chk("mid_valid_before", bus.valid_out, 1); chk("mid_state_before", state, 3); post(x);
    x = mk(0,1,3,3,'h03,0,'h04,0,0,0); pre(x);
    chk("mid_valid_dropped", bus.valid_out, 0); chk("mid_data_cleared", bus.data_out, 0);
    chk("mid_state_reset", state, 0); chk("mid_pop0_rst", bus.pop0, 0);
    chk("mid_pop1_rst", bus.pop1, 0); chk("mid_idle_rst", idle, 0);
`ifdef DEMUX_FLOW_CTRL_STATS_EN
    chk("mid_sent0_clr", sent_cnt0, 0); chk("mid_sent1_clr", sent_cnt1, 0);
`endif
    post(x);
    x = mk(0,1,3,3,'h03,0,'h04,0,0,0); pre(x);
    chk("mid_init_state", state, 1); chk("mid_init_pop0", bus.pop0, 0); chk("mid_init_pop1", bus.pop1, 0); post(x);
    x = mk(0,0,3,3,'h03,0,'h04,0,0,0); pre(x);
    chk("mid_init2_state", state, 1); chk("mid_init2_pops", bus.pop0 | bus.pop1, 0); post(x);
    x = mk(0,0,3,3,'h03,0,'h04,0,0,0); pre(x);
    chk("mid_resume_state", state, 2); chk("mid_resume_pop", bus.pop0 ^ bus.pop1, 1); post(x);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit lp0, lp1;
      lp0 = ($urandom_range(0, 3) == 0) && (cred[0] < lim[0] || $urandom_range(0, 49) == 0);
      lp1 = ($urandom_range(0, 3) == 0) && (cred[1] < lim[1] || $urandom_range(0, 49) == 0);
      x = mk(($urandom_range(0, 149) == 0), ($urandom_range(0, 15) == 0),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 63)), ($urandom_range(0, 4) < 2),
             int'($urandom_range(0, 63)), ($urandom_range(0, 4) < 2), lp0, lp1);
      cyc(x);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
